// File: rtl/serial_divisible_by_3.sv
// Bit-serial, MSB-first divisibility-by-3 checker. It tracks the running remainder mod 3 and reports it one cycle after the last bit.
// The word is accepted on WIDTH beats after start. There is no backpressure: bit_valid_i gaps simply stall the word.
module serial_divisible_by_3 #(
  parameter int WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         bit_valid_i,
  input  logic                         bit_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [1:0]                   rem_o,
  output logic                         y_o,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state;
  logic [1:0] r;
  logic [1:0] next_r;

  // Appending a bit doubles the value and adds the bit, so r' = (2r + b) mod 3.
  always_comb begin
    next_r = 2'd0;
    case (r)
      2'd0:    next_r = bit_i ? 2'd1 : 2'd0;
      2'd1:    next_r = bit_i ? 2'd0 : 2'd2;
      2'd2:    next_r = bit_i ? 2'd2 : 2'd1;
      default: next_r = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      rem_o   <= 2'd0;
      y_o     <= 1'b0;
      count_o <= '0;
      r       <= 2'd0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= SHIFT;
            busy_o  <= 1'b1;
            r       <= 2'd0;
            count_o <= '0;
          end
        end
        SHIFT: begin
          if (start_i) begin
            r       <= 2'd0;
            count_o <= '0;
          end else if (bit_valid_i) begin
            r       <= next_r;
            count_o <= count_o + CW'(1);
            if (count_o == LAST) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              rem_o  <= next_r;
              y_o    <= (next_r == 2'd0);
            end
          end
        end
        DONE: begin
          if (start_i) begin
            state   <= SHIFT;
            busy_o  <= 1'b1;
            r       <= 2'd0;
            count_o <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divisible_by_3.sv
// Self-checking bench for serial_divisible_by_3 at WIDTH=4 and WIDTH=8, with a queue scoreboard of expected results.
module tb_serial_divisible_by_3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start4 = 1'b0, bv4 = 1'b0, bit4 = 1'b0;
  logic       busy4, done4, y4;
  logic [1:0] rem4;
  logic [2:0] cnt4;

  logic       start8 = 1'b0, bv8 = 1'b0, bit8 = 1'b0;
  logic       busy8, done8, y8;
  logic [1:0] rem8;
  logic [3:0] cnt8;

  typedef struct packed {
    logic [1:0] rem;
    logic       y;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t last4;
  int   total = 0;
  int   bad   = 0;

  serial_divisible_by_3 #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .bit_valid_i(bv4), .bit_i(bit4),
    .busy_o(busy4), .done_o(done4), .rem_o(rem4), .y_o(y4), .count_o(cnt4)
  );

  serial_divisible_by_3 #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .bit_valid_i(bv8), .bit_i(bit8),
    .busy_o(busy8), .done_o(done8), .rem_o(rem8), .y_o(y8), .count_o(cnt8)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int v);
    exp_t m;
    m.rem = 2'(v % 3);
    m.y   = ((v % 3) == 0);
    return m;
  endfunction

  // Inputs change on the falling edge; outputs are read at the next falling edge.
  task automatic step4(input logic s, input logic v, input logic b);
    start4 = s; bv4 = v; bit4 = b;
    @(negedge clk);
  endtask

  task automatic step8(input logic s, input logic v, input logic b);
    start8 = s; bv8 = v; bit8 = b;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || rem4 !== 2'd0 || y4 !== 1'b0 || cnt4 !== 3'd0) begin
      bad++;
      $display("FAIL reset4: busy=%b done=%b rem=%0d y=%b cnt=%0d, want all 0", busy4, done4, rem4, y4, cnt4);
    end
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || rem8 !== 2'd0 || y8 !== 1'b0 || cnt8 !== 4'd0) begin
      bad++;
      $display("FAIL reset8: busy=%b done=%b rem=%0d y=%b cnt=%0d, want all 0", busy8, done8, rem8, y8, cnt8);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exhaustive;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, 1'b0, 1'b0);
      total++;
      if (busy4 !== 1'b1 || cnt4 !== 3'd0) begin
        bad++;
        $display("FAIL exh_start i=%0d: busy=%b cnt=%0d, want busy=1 cnt=0", i, busy4, cnt4);
      end
      q4.push_back(model(i));
      for (int k = 3; k >= 0; k--) begin
        step4(1'b0, 1'b1, i[k]);
        if (k > 0) begin
          total++;
          if (done4 !== 1'b0 || cnt4 !== 3'(4 - k)) begin
            bad++;
            $display("FAIL exh_progress i=%0d bit=%0d: done=%b cnt=%0d, want done=0 cnt=%0d", i, k, done4, cnt4, 4 - k);
          end
        end
      end
      total++;
      if (done4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 3'd4) begin
        bad++;
        $display("FAIL exh_latency i=%0d: done=%b busy=%b cnt=%0d, want done=1 busy=0 cnt=4", i, done4, busy4, cnt4);
      end
      e = q4.pop_front();
      last4 = e;
      total++;
      if (rem4 !== e.rem || y4 !== e.y) begin
        bad++;
        $display("FAIL exh_result i=%0d: rem=%0d y=%b, want rem=%0d y=%b", i, rem4, y4, e.rem, e.y);
      end
      step4(1'b0, 1'b0, 1'b0);
      total++;
      if (done4 !== 1'b0 || cnt4 !== 3'd4 || rem4 !== e.rem) begin
        bad++;
        $display("FAIL exh_pulse i=%0d: done=%b cnt=%0d rem=%0d, want done=0 cnt=4 rem=%0d", i, done4, cnt4, rem4, e.rem);
      end
    end
  endtask

  task automatic test_gapped;
    logic [3:0] bits;
    exp_t e;
    bits = 4'b1100;
    step4(1'b1, 1'b0, 1'b0);
    q4.push_back(model(12));
    for (int k = 3; k >= 0; k--) begin
      step4(1'b0, 1'b1, bits[k]);
      if (k > 0) begin
        for (int g = 0; g < 3; g++) begin
          step4(1'b0, 1'b0, 1'b1);
          total++;
          if (busy4 !== 1'b1 || done4 !== 1'b0 || cnt4 !== 3'(4 - k)) begin
            bad++;
            $display("FAIL gap_hold bit=%0d gap=%0d: busy=%b done=%b cnt=%0d, want busy=1 done=0 cnt=%0d",
                     k, g, busy4, done4, cnt4, 4 - k);
          end
        end
      end
    end
    total++;
    if (done4 !== 1'b1) begin
      bad++;
      $display("FAIL gap_done: done=%b, want 1", done4);
    end
    e = q4.pop_front();
    last4 = e;
    total++;
    if (rem4 !== e.rem || y4 !== e.y) begin
      bad++;
      $display("FAIL gap_result: rem=%0d y=%b, want rem=%0d y=%b", rem4, y4, e.rem, e.y);
    end
    step4(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    logic [3:0] bits;
    exp_t e;
    bits = 4'b0111;
    step4(1'b1, 1'b0, 1'b0);
    step4(1'b0, 1'b1, 1'b1);
    step4(1'b0, 1'b1, 1'b1);
    total++;
    if (cnt4 !== 3'd2 || rem4 !== last4.rem || y4 !== last4.y) begin
      bad++;
      $display("FAIL abort_before: cnt=%0d rem=%0d y=%b, want cnt=2 rem=%0d y=%b", cnt4, rem4, y4, last4.rem, last4.y);
    end
    step4(1'b1, 1'b1, 1'b1);
    total++;
    if (cnt4 !== 3'd0 || busy4 !== 1'b1 || done4 !== 1'b0 || rem4 !== last4.rem || y4 !== last4.y) begin
      bad++;
      $display("FAIL abort_restart: cnt=%0d busy=%b done=%b rem=%0d y=%b, want cnt=0 busy=1 done=0 rem=%0d y=%b",
               cnt4, busy4, done4, rem4, y4, last4.rem, last4.y);
    end
    q4.push_back(model(7));
    for (int k = 3; k >= 0; k--) begin
      step4(1'b0, 1'b1, bits[k]);
      if (k > 0) begin
        total++;
        if (done4 !== 1'b0 || rem4 !== last4.rem) begin
          bad++;
          $display("FAIL abort_progress bit=%0d: done=%b rem=%0d, want done=0 rem=%0d", k, done4, rem4, last4.rem);
        end
      end
    end
    e = q4.pop_front();
    last4 = e;
    total++;
    if (done4 !== 1'b1 || rem4 !== e.rem || y4 !== e.y) begin
      bad++;
      $display("FAIL abort_result: done=%b rem=%0d y=%b, want done=1 rem=%0d y=%b", done4, rem4, y4, e.rem, e.y);
    end
    step4(1'b0, 1'b0, 1'b0);
    total++;
    if (done4 !== 1'b0) begin
      bad++;
      $display("FAIL abort_single_done: done=%b, want 0", done4);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] bits;
    exp_t e;
    bits = 4'd6;
    step4(1'b1, 1'b0, 1'b0);
    q4.push_back(model(6));
    for (int k = 3; k >= 0; k--) step4(1'b0, 1'b1, bits[k]);
    e = q4.pop_front();
    total++;
    if (done4 !== 1'b1 || rem4 !== e.rem || y4 !== e.y) begin
      bad++;
      $display("FAIL rmid_first: done=%b rem=%0d y=%b, want done=1 rem=%0d y=%b", done4, rem4, y4, e.rem, e.y);
    end
    step4(1'b0, 1'b0, 1'b0);
    step4(1'b1, 1'b0, 1'b0);
    step4(1'b0, 1'b1, 1'b0);
    step4(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    #2;
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || rem4 !== 2'd0 || y4 !== 1'b0 || cnt4 !== 3'd0) begin
      bad++;
      $display("FAIL rmid_async: busy=%b done=%b rem=%0d y=%b cnt=%0d, want all 0", busy4, done4, rem4, y4, cnt4);
    end
    @(negedge clk);
    rst = 1'b0;
    step4(1'b0, 1'b1, 1'b1);
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || cnt4 !== 3'd0) begin
      bad++;
      $display("FAIL rmid_idle: busy=%b done=%b cnt=%0d, want busy=0 done=0 cnt=0", busy4, done4, cnt4);
    end
    bits = 4'd3;
    step4(1'b1, 1'b0, 1'b0);
    q4.push_back(model(3));
    for (int k = 3; k >= 0; k--) step4(1'b0, 1'b1, bits[k]);
    e = q4.pop_front();
    last4 = e;
    total++;
    if (done4 !== 1'b1 || rem4 !== e.rem || y4 !== e.y) begin
      bad++;
      $display("FAIL rmid_after: done=%b rem=%0d y=%b, want done=1 rem=%0d y=%b", done4, rem4, y4, e.rem, e.y);
    end
    step4(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [3:0] bits;
    exp_t e;
    bits = 4'd5;
    step4(1'b1, 1'b0, 1'b0);
    q4.push_back(model(5));
    for (int k = 3; k >= 0; k--) step4(1'b0, 1'b1, bits[k]);
    e = q4.pop_front();
    total++;
    if (done4 !== 1'b1 || rem4 !== e.rem || y4 !== e.y) begin
      bad++;
      $display("FAIL b2b_first: done=%b rem=%0d y=%b, want done=1 rem=%0d y=%b", done4, rem4, y4, e.rem, e.y);
    end
    bits = 4'd15;
    q4.push_back(model(15));
    step4(1'b1, 1'b0, 1'b0);
    total++;
    if (busy4 !== 1'b1 || done4 !== 1'b0 || cnt4 !== 3'd0) begin
      bad++;
      $display("FAIL b2b_restart: busy=%b done=%b cnt=%0d, want busy=1 done=0 cnt=0", busy4, done4, cnt4);
    end
    for (int k = 3; k >= 0; k--) begin
      step4(1'b0, 1'b1, bits[k]);
      if (k > 0) begin
        total++;
        if (done4 !== 1'b0) begin
          bad++;
          $display("FAIL b2b_early bit=%0d: done=%b, want 0", k, done4);
        end
      end
    end
    e = q4.pop_front();
    last4 = e;
    total++;
    if (done4 !== 1'b1 || rem4 !== e.rem || y4 !== e.y) begin
      bad++;
      $display("FAIL b2b_second: done=%b rem=%0d y=%b, want done=1 rem=%0d y=%b", done4, rem4, y4, e.rem, e.y);
    end
    step4(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_width8;
    int         words[3];
    logic [7:0] v;
    exp_t       e;
    words = '{255, 254, 0};
    for (int p = 0; p < 3; p++) begin
      step8(1'b0, 1'b1, 1'b1);
      total++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || cnt8 !== 4'd0) begin
        bad++;
        $display("FAIL w8_idle_pre p=%0d: done=%b busy=%b cnt=%0d, want 0 0 0", p, done8, busy8, cnt8);
      end
    end
    for (int w = 0; w < 3; w++) begin
      v = 8'(words[w]);
      step8(1'b1, 1'b0, 1'b0);
      q8.push_back(model(words[w]));
      for (int k = 7; k >= 0; k--) begin
        step8(1'b0, 1'b1, v[k]);
        if (k > 0) begin
          total++;
          if (done8 !== 1'b0 || cnt8 !== 4'(8 - k)) begin
            bad++;
            $display("FAIL w8_progress w=%0d bit=%0d: done=%b cnt=%0d, want done=0 cnt=%0d", words[w], k, done8, cnt8, 8 - k);
          end
        end
      end
      e = q8.pop_front();
      total++;
      if (done8 !== 1'b1 || cnt8 !== 4'd8 || rem8 !== e.rem || y8 !== e.y) begin
        bad++;
        $display("FAIL w8_result w=%0d: done=%b cnt=%0d rem=%0d y=%b, want done=1 cnt=8 rem=%0d y=%b",
                 words[w], done8, cnt8, rem8, y8, e.rem, e.y);
      end
      step8(1'b0, 1'b0, 1'b0);
    end
    for (int p = 0; p < 3; p++) begin
      step8(1'b0, 1'b1, 1'b0);
      total++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || cnt8 !== 4'd8) begin
        bad++;
        $display("FAIL w8_idle_post p=%0d: done=%b busy=%b cnt=%0d, want 0 0 8", p, done8, busy8, cnt8);
      end
    end
  endtask

  initial begin
    last4 = '0;
    test_reset();
    test_exhaustive();
    test_gapped();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_width8();
    total++;
    if (q4.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: q4=%0d q8=%0d left, want 0", q4.size(), q8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
